// File: rtl/fsm_rx.sv
`default_nettype none
// ============================================================================
// Module      : fsm_rx
// Description : Receive-side command decoder for a UART link. It turns the
//               incoming byte stream into command codes for the transmit FSM
//               and accepts a checksummed configuration frame:
//                   0x43, N[31:24], N[23:16], N[15:8], N[7:0], XOR checksum
//               The checksum is the XOR of the command byte and all four
//               payload bytes.
//
// Ports       : clk          - single clock, posedge
//               rst          - synchronous active-high reset
//               rx_data      - byte from the UART receiver
//               rx_valid     - one-cycle strobe qualifying rx_data
//               rx_out       - decoded command code (held between commands)
//               control      - high while a valid configuration is active
//               config_N_ref - reference count from the last good config frame
//               cfg_rdy      - one-cycle pulse when config_N_ref is updated
//               err          - one-cycle pulse on any rejected byte or frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_rx #(
    parameter int SIZE    = 32,       // payload is four bytes; must stay 32
    parameter int TIMEOUT = 1000000   // max idle clk cycles between frame bytes
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic [3:0]      rx_out,
    output logic            control,
    output logic [SIZE-1:0] config_N_ref,
    output logic            cfg_rdy,
    output logic            err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [TMR_W-1:0] c_TIMEOUT = TMR_W'(TIMEOUT);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
    localparam logic [1:0] c_ST_CHECK   = 2'd2;

    localparam logic [7:0] c_CMD_CFG     = 8'h43;
    localparam logic [7:0] c_CMD_T_SGL   = 8'h54;
    localparam logic [7:0] c_CMD_T_CONT  = 8'h74;
    localparam logic [7:0] c_CMD_D_SGL   = 8'h44;
    localparam logic [7:0] c_CMD_D_CONT  = 8'h64;
    localparam logic [7:0] c_CMD_STOP    = 8'h53;

    localparam logic [3:0] c_CODE_CFG    = 4'b0111;
    localparam logic [3:0] c_CODE_T_SGL  = 4'b0001;
    localparam logic [3:0] c_CODE_T_CONT = 4'b0100;
    localparam logic [3:0] c_CODE_D_SGL  = 4'b0010;
    localparam logic [3:0] c_CODE_D_CONT = 4'b1000;
    localparam logic [3:0] c_CODE_NONE   = 4'b0000;

    // ------------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------------
    logic [1:0]      r_state,      w_state_nxt;
    logic [1:0]      r_byte_cnt,   w_byte_cnt_nxt;
    logic [SIZE-1:0] r_shadow,     w_shadow_nxt;
    logic [7:0]      r_csum,       w_csum_nxt;
    logic [TMR_W-1:0] r_timer,     w_timer_nxt;
    logic [3:0]      r_rx_out,     w_rx_out_nxt;
    logic            r_control,    w_control_nxt;
    logic [SIZE-1:0] r_cfg_ref,    w_cfg_ref_nxt;
    logic            r_cfg_rdy,    w_cfg_rdy_nxt;
    logic            r_err,        w_err_nxt;

    // Measurement command lookup. These commands are only honoured once a
    // configuration is active.
    logic            w_is_meas;
    logic [3:0]      w_meas_code;

    always_comb begin
        w_is_meas   = 1'b1;
        w_meas_code = c_CODE_NONE;
        case (rx_data)
            c_CMD_T_SGL:  w_meas_code = c_CODE_T_SGL;
            c_CMD_T_CONT: w_meas_code = c_CODE_T_CONT;
            c_CMD_D_SGL:  w_meas_code = c_CODE_D_SGL;
            c_CMD_D_CONT: w_meas_code = c_CODE_D_CONT;
            default:      w_is_meas   = 1'b0;
        endcase
    end

    // Frame-expiry: mid-frame with no byte arriving on the cycle the idle
    // counter has reached its limit. A byte on that same cycle wins.
    logic w_timeout;
    assign w_timeout = (r_state != c_ST_IDLE) && !rx_valid && (r_timer == c_TIMEOUT);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shadow_nxt   = r_shadow;
        w_csum_nxt     = r_csum;
        w_timer_nxt    = r_timer;
        w_rx_out_nxt   = r_rx_out;
        w_control_nxt  = r_control;
        w_cfg_ref_nxt  = r_cfg_ref;
        w_cfg_rdy_nxt  = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_timer_nxt = '0;
                if (rx_valid) begin
                    if (rx_data == c_CMD_CFG) begin
                        w_state_nxt    = c_ST_PAYLOAD;
                        w_byte_cnt_nxt = 2'd0;
                        w_csum_nxt     = c_CMD_CFG;
                        w_shadow_nxt   = '0;
                    end else if (rx_data == c_CMD_STOP) begin
                        w_control_nxt = 1'b0;
                        w_rx_out_nxt  = c_CODE_NONE;
                    end else if (w_is_meas) begin
                        if (r_control) begin
                            w_rx_out_nxt = w_meas_code;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            c_ST_PAYLOAD: begin
                if (rx_valid) begin
                    // Bytes arrive MSB first, so shift left.
                    w_shadow_nxt   = {r_shadow[SIZE-9:0], rx_data};
                    w_csum_nxt     = r_csum ^ rx_data;
                    w_timer_nxt    = '0;
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = c_ST_CHECK;
                    end
                end else if (w_timeout) begin
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = c_ST_IDLE;
                    w_shadow_nxt = '0;
                    w_timer_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end

            c_ST_CHECK: begin
                if (rx_valid) begin
                    w_state_nxt = c_ST_IDLE;
                    w_timer_nxt = '0;
                    if (rx_data == r_csum) begin
                        w_cfg_ref_nxt = r_shadow;
                        w_control_nxt = 1'b1;
                        w_rx_out_nxt  = c_CODE_CFG;
                        w_cfg_rdy_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = c_ST_IDLE;
                    w_shadow_nxt = '0;
                    w_timer_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_byte_cnt <= 2'd0;
            r_shadow   <= '0;
            r_csum     <= 8'h00;
            r_timer    <= '0;
            r_rx_out   <= c_CODE_NONE;
            r_control  <= 1'b0;
            r_cfg_ref  <= '0;
            r_cfg_rdy  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_shadow   <= w_shadow_nxt;
            r_csum     <= w_csum_nxt;
            r_timer    <= w_timer_nxt;
            r_rx_out   <= w_rx_out_nxt;
            r_control  <= w_control_nxt;
            r_cfg_ref  <= w_cfg_ref_nxt;
            r_cfg_rdy  <= w_cfg_rdy_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign rx_out       = r_rx_out;
    assign control      = r_control;
    assign config_N_ref = r_cfg_ref;
    assign cfg_rdy      = r_cfg_rdy;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fsm_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_rx
// Description : Directed self-checking bench for fsm_rx. Bytes are driven on
//               the falling edge and outputs are sampled on the falling edge
//               after the rising edge that captured the byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_rx;

    localparam int SIZE    = 32;
    localparam int TIMEOUT = 20;

    logic            clk;
    logic            rst;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [3:0]      rx_out;
    logic            control;
    logic [SIZE-1:0] config_N_ref;
    logic            cfg_rdy;
    logic            err;

    int n_tests = 0;
    int n_fail  = 0;

    fsm_rx #(
        .SIZE    (SIZE),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_out       (rx_out),
        .control      (control),
        .config_N_ref (config_N_ref),
        .cfg_rdy      (cfg_rdy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller sits on a falling edge; returns on the next falling edge, when
    // the outputs produced by this byte are visible.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        chk("rst_rx_out",  32'(rx_out),  32'h0);
        chk("rst_control", 32'(control), 32'h0);
        chk("rst_cfg",     config_N_ref, 32'h0);
        chk("rst_cfg_rdy", 32'(cfg_rdy), 32'h0);
        chk("rst_err",     32'(err),     32'h0);
        rst = 1'b0;
        idle(1);

        // Measurement command without configuration is rejected.
        send(8'h44);
        chk("nocfg_err",     32'(err),     32'h1);
        chk("nocfg_rx_out",  32'(rx_out),  32'h0);
        chk("nocfg_control", 32'(control), 32'h0);
        idle(1);
        chk("nocfg_err_one", 32'(err),     32'h0);

        // Good configuration frame.
        send(8'h43); send(8'h00); send(8'h00); send(8'h01); send(8'hF4);
        chk("cfg_pre_rdy",  32'(cfg_rdy), 32'h0);
        chk("cfg_pre_ctrl", 32'(control), 32'h0);
        send(8'hB6);
        chk("cfg_value",   config_N_ref,  32'h0000_01F4);
        chk("cfg_control", 32'(control), 32'h1);
        chk("cfg_rx_out",  32'(rx_out),  32'h7);
        chk("cfg_rdy",     32'(cfg_rdy), 32'h1);
        chk("cfg_err",     32'(err),     32'h0);
        idle(1);
        chk("cfg_rdy_one", 32'(cfg_rdy), 32'h0);
        chk("cfg_hold",    config_N_ref,  32'h0000_01F4);

        // Measurement commands with an active configuration.
        send(8'h74); chk("t_cont", 32'(rx_out), 32'h4);
        send(8'h54); chk("t_sgl",  32'(rx_out), 32'h1);
        send(8'h44); chk("d_sgl",  32'(rx_out), 32'h2);
        send(8'h64); chk("d_cont", 32'(rx_out), 32'h8);
        chk("meas_err", 32'(err), 32'h0);
        idle(4);
        chk("meas_hold", 32'(rx_out), 32'h8);

        // Stop.
        send(8'h53);
        chk("stop_rx_out",  32'(rx_out),  32'h0);
        chk("stop_control", 32'(control), 32'h0);
        chk("stop_cfg",     config_N_ref,  32'h0000_01F4);

        // New good frame (N = 0x0A), then a bad-checksum frame.
        send(8'h43); send(8'h00); send(8'h00); send(8'h00); send(8'h0A); send(8'h49);
        chk("cfg2_value", config_N_ref, 32'h0000_000A);
        send(8'h43); send(8'h00); send(8'h00); send(8'h01); send(8'hF4); send(8'h00);
        chk("bad_err",     32'(err),     32'h1);
        chk("bad_cfg_rdy", 32'(cfg_rdy), 32'h0);
        chk("bad_control", 32'(control), 32'h1);
        chk("bad_cfg",     config_N_ref,  32'h0000_000A);
        chk("bad_rx_out",  32'(rx_out),  32'h7);

        // Command values inside a frame are plain data.
        send(8'h43); send(8'h53); send(8'h54); send(8'h74); send(8'h44);
        chk("data_no_err", 32'(err),     32'h0);
        chk("data_ctrl",   32'(control), 32'h1);
        send(8'h74);
        chk("data_cfg", config_N_ref, 32'h5354_7444);
        chk("data_rdy", 32'(cfg_rdy), 32'h1);

        // Unknown byte in IDLE.
        send(8'hFF);
        chk("unk_err",     32'(err),     32'h1);
        chk("unk_rx_out",  32'(rx_out),  32'h7);
        chk("unk_control", 32'(control), 32'h1);

        // Inter-byte timeout, then a following frame is accepted.
        send(8'h43); send(8'h12);
        idle(TIMEOUT);
        chk("tmo_early", 32'(err), 32'h0);
        idle(1);
        chk("tmo_err", 32'(err), 32'h1);
        idle(1);
        chk("tmo_err_one", 32'(err), 32'h0);
        send(8'h43); send(8'h00); send(8'h00); send(8'h00); send(8'h0A); send(8'h49);
        chk("tmo_recover_rdy", 32'(cfg_rdy), 32'h1);
        chk("tmo_recover_cfg", config_N_ref,  32'h0000_000A);

        // Byte arriving on the very cycle the limit is reached is accepted.
        send(8'h43); send(8'h12);
        idle(TIMEOUT);
        send(8'h00);
        chk("edge_no_err", 32'(err), 32'h0);
        send(8'h00); send(8'h01); send(8'h50);
        chk("edge_cfg", config_N_ref, 32'h1200_0001);
        chk("edge_rdy", 32'(cfg_rdy), 32'h1);

        // Reset mid-frame discards the partial frame.
        send(8'h43); send(8'h00); send(8'h00);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_control", 32'(control), 32'h0);
        chk("mid_rst_cfg",     config_N_ref,  32'h0);
        send(8'h54);
        chk("mid_rst_err",    32'(err),     32'h1);
        chk("mid_rst_rx_out", 32'(rx_out),  32'h0);
        chk("mid_rst_ctrl2",  32'(control), 32'h0);
        send(8'h00); send(8'h00);
        chk("mid_rst_no_rdy", 32'(cfg_rdy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_rx.md
FSM_RX -- requirements
Module: fsm_rx

Interface
REQ-001 Parameter SIZE, default 32, width of config_N_ref; SHALL be fixed at 32 (payload is 4 bytes).
REQ-002 Parameter TIMEOUT, default 1000000, maximum clk cycles allowed between bytes of one frame.
REQ-003 clk  input  1  single clock; all logic SHALL be on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data valid when high.
REQ-007 rx_out  output  4  decoded command code for the transmit FSM.
REQ-008 control  output  1  high while a valid configuration is active.
REQ-009 config_N_ref  output  SIZE  reference count loaded by the configuration frame.
REQ-010 cfg_rdy  output  1  one-cycle pulse when config_N_ref is updated.
REQ-011 err  output  1  one-cycle pulse on any rejected byte or frame.

Function
REQ-012 Command bytes SHALL be: 0x43 config, 0x54 single temp, 0x74 continuous temp, 0x44 single dist, 0x64 continuous dist, 0x53 stop.
REQ-013 Codes driven on rx_out SHALL be: config 4'b0111, single temp 4'b0001, continuous temp 4'b0100, single dist 4'b0010, continuous dist 4'b1000, stop/none 4'b0000.
REQ-014 States SHALL be IDLE, PAYLOAD and CHECK.
REQ-015 Config frame: 0x43, 4 payload bytes MSB first, then 1 checksum byte equal to XOR of the command byte and the 4 payload bytes.
REQ-016 IDLE + rx_valid with 0x43 -> PAYLOAD; byte counter cleared and checksum accumulator seeded with 0x43.
REQ-017 PAYLOAD: each rx_valid shifts rx_data into a shadow register and XORs it into the accumulator; after the 4th byte -> CHECK.
REQ-018 CHECK + rx_valid: on match, config_N_ref <= shadow, control <= 1, rx_out <= 4'b0111, cfg_rdy pulses, -> IDLE; on mismatch, err pulses, outputs unchanged, -> IDLE.
REQ-019 Outputs from a frame-completing byte SHALL be visible on the cycle after the rx_valid cycle (latency 1).
REQ-020 IDLE + measurement command with control==1: rx_out <= its code; with control==0: err pulses and rx_out is unchanged.
REQ-021 IDLE + 0x53: control <= 0 and rx_out <= 4'b0000; config_N_ref is retained.
REQ-022 IDLE + any other byte: err pulses; no other output changes.
REQ-023 In PAYLOAD/CHECK, every byte SHALL be treated as frame data; command values are not decoded.
REQ-024 Inter-byte counter: cleared on each rx_valid; increments in PAYLOAD/CHECK. On reaching TIMEOUT, err pulses, the shadow register is discarded and the FSM returns to IDLE.
REQ-025 If rx_valid occurs in the same cycle the counter reaches TIMEOUT, the byte SHALL be accepted and the timeout suppressed.
REQ-026 rx_out, control and config_N_ref SHALL hold their values between commands.
REQ-027 cfg_rdy and err SHALL never be high in the same cycle.

Reset
REQ-028 While rst is high: state = IDLE, rx_out = 4'b0000, control = 0, config_N_ref = 0, cfg_rdy = 0, err = 0, and the counters and shadow register are cleared.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first byte after reset is decoded in IDLE.

Verification
REQ-030 Bytes 43 00 00 01 F4 B6 -> next cycle config_N_ref = 0x000001F4, control = 1, rx_out = 0111, cfg_rdy high for 1 cycle.
REQ-031 After REQ-030, byte 74 -> rx_out = 0100; then byte 53 -> rx_out = 0000, control = 0, config_N_ref still 0x000001F4.
REQ-032 From reset, byte 44 -> err pulse; rx_out stays 0000 and control stays 0.
REQ-033 Bytes 43 00 00 01 F4 00 (bad checksum) -> err pulse; control and config_N_ref unchanged.
REQ-034 Bytes 43 12, then no byte for TIMEOUT cycles -> err pulse and return to IDLE; a following complete valid frame is accepted.
REQ-035 Bytes 43 00 00, rst high 1 cycle, then 54 -> err pulse (control = 0 after reset); no frame completes.
